ysyx_rob: RTL
=============

YSYX_ROB -- requirements
Module: ysyx_rob

Interface
REQ-001 The block SHALL have parameter ROB_SIZE, default `YSYX_ROB_SIZE` (4), giving the number of reorder entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter XLEN, default `YSYX_XLEN` (32), giving the data and PC width.
REQ-003 Tags SHALL be TW = $clog2(ROB_SIZE)+1 bits wide; tag 0 means "no producer", and tag k (1..ROB_SIZE) names entry k-1.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 The clock port SHALL be: clock  in  1  rising-edge clock.
REQ-006 The reset port SHALL be: reset  in  1  asynchronous active-low reset.
REQ-007 Allocation ports SHALL be:
- alloc_valid  in  1  IDU issues an instruction.
- alloc_ready  out  1  an entry is free.
- alloc_rd  in  5  destination register.
- alloc_pc  in  XLEN  PC of the instruction.
- alloc_inst  in  32  instruction word.
- alloc_dest  out  TW  tag granted, equal to tail+1.
REQ-008 Operand lookup ports SHALL be:
- rs1, rs2  in  5  source registers.
- qj, qk  out  TW  pending producer tag, 0 if none.
- vj, vk  out  XLEN  forwarded value.
- vj_fwd, vk_fwd  out  1  forwarded value valid.
REQ-009 Writeback ports (EXU side) SHALL be:
- wb_valid  in  1  result valid.
- wb_dest  in  TW  tag of the producing entry.
- wb_result  in  XLEN  result value.
- wb_npc  in  XLEN  next PC.
- wb_pc_change  in  1  redirect required.
- wb_ebreak  in  1  instruction is an ebreak.
REQ-010 Commit ports SHALL be:
- cmt_valid  out  1  one-cycle retire pulse.
- cmt_rd  out  5  retired destination register.
- cmt_data  out  XLEN  retired result.
- cmt_pc  out  XLEN  retired PC.
- cmt_npc  out  XLEN  retired next PC.
- cmt_inst  out  32  retired instruction word.
- cmt_ebreak  out  1  retired instruction was an ebreak.
- flush  out  1  one-cycle pipeline flush.

Function
REQ-011 The entry storage SHALL be a circular buffer with head, tail and count; head and tail SHALL wrap from ROB_SIZE-1 to 0.
REQ-012 Each entry SHALL hold: busy, done, rd, pc, inst, result, npc, pc_change, ebreak.
REQ-013 alloc_ready SHALL equal (count < ROB_SIZE) and SHALL NOT take account of a retire in the same cycle.
REQ-014 alloc_dest SHALL be combinational and equal tail+1.
REQ-015 On a rising edge with alloc_valid && alloc_ready, the block SHALL:
- write the entry at tail with busy=1 and done=0;
- advance tail;
- if alloc_rd != 0, set map[alloc_rd] = alloc_dest.
REQ-016 On a rising edge with wb_valid, wb_dest != 0 and entry wb_dest-1 busy, the block SHALL set done=1 and store result, npc, pc_change and ebreak.
REQ-017 Writebacks with wb_dest == 0, or to a non-busy entry, SHALL be ignored.
REQ-018 On each rising edge where entry[head] is busy and done, the block SHALL retire it:
- clear busy;
- advance head;
- register cmt_* from the entry and assert cmt_valid for exactly one cycle.
REQ-019 At most one entry SHALL retire per cycle.
REQ-020 The earliest retire SHALL occur at the edge following the writeback edge.
REQ-021 On retire, if map[rd] equals the retiring tag, map[rd] SHALL be cleared to 0.
REQ-022 If an allocation to the same rd occurs in that cycle, the allocation's map write SHALL win over the retire's clear.
REQ-023 count SHALL be updated +1 on allocate, -1 on retire, and left unchanged when both occur.
REQ-024 Retiring an entry with pc_change=1 SHALL:
- assert flush in the same cycle as cmt_valid;
- clear all busy/done bits;
- set head=tail=count=0;
- clear the whole map.
REQ-025 An allocation accepted on the edge where a pc_change entry retires SHALL be discarded.
REQ-026 A retiring entry with ebreak=1 SHALL assert cmt_ebreak with cmt_valid and SHALL NOT flush.
REQ-027 Lookup SHALL be combinational:
- qj=0, vj_fwd=0 if rs1==0 or map[rs1]==0;
- qj=0, vj_fwd=1, vj=entry result if the mapped entry is done;
- otherwise qj=map[rs1], vj_fwd=0.
REQ-028 rs2/qk/vk/vk_fwd SHALL follow the same rule as REQ-027.
REQ-029 A same-cycle writeback SHALL NOT be bypassed to lookup.
REQ-030 vj and vk SHALL be 0 whenever the corresponding *_fwd is 0.

Reset
REQ-031 While reset is low, the block SHALL hold head=tail=count=0, all busy/done bits 0, and all map entries 0.
REQ-032 While reset is low, cmt_valid, cmt_ebreak and flush SHALL be 0 and all cmt_* data SHALL be 0.
REQ-033 Asserting reset mid-operation SHALL drop all in-flight entries immediately, without waiting for a clock edge.
REQ-034 After reset, alloc_ready SHALL be 1.

Verification (ROB_SIZE=4)
REQ-035 Allocate rd=5 at pc 0x80000000 → alloc_dest=1; lookup rs1=5 → qj=1, vj_fwd=0; wb dest=1, result=0x2A → next cycle qj=0, vj_fwd=1, vj=0x2A; next edge cmt_valid=1, cmt_rd=5, cmt_data=0x2A.
REQ-036 Allocate 4 entries with no writeback → alloc_dest 1,2,3,4 and alloc_ready=0; a 5th alloc_valid is not accepted.
REQ-037 Writeback order 3,2,1 → retires in order 1,2,3 on consecutive cycles, no gaps after tag 1 is done.
REQ-038 Entry 1 with pc_change=1, npc=0x80000100, entries 2-3 busy → cmt_valid=1 and flush=1 together, cmt_npc=0x80000100, count=0, next alloc_dest=1.
REQ-039 Entry with wb_ebreak=1 retires → cmt_ebreak=1, flush=0.
REQ-040 Reset pulled low with 3 busy entries between clock edges → cmt_valid=0 and alloc_ready=1 immediately; qj=0 for all registers.

Source files
------------

// File: rtl/ysyx_rob.sv
// ysyx_rob: reorder buffer. It allocates entries in program order, keeps a register-to-tag
// rename map, accepts out-of-order writebacks and retires at most one finished entry per
// cycle from the head.
//
// Ports:
//   clock, reset                rising-edge clock, asynchronous active-low reset
//   alloc_valid/ready/rd/pc/inst/dest   allocation from IDU; dest is the granted tag (tail+1)
//   rs1/rs2 -> qj/qk, vj/vk, vj_fwd/vk_fwd   combinational operand lookup
//   wb_valid/dest/result/npc/pc_change/ebreak   writeback from EXU
//   cmt_valid/rd/data/pc/npc/inst/ebreak, flush   registered commit outputs
//
// Tags are 1-based: tag 0 means "no producer", and tag k names entry k-1.

`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 4
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_rob #(
  parameter int unsigned ROB_SIZE = `YSYX_ROB_SIZE,
  parameter int unsigned XLEN     = `YSYX_XLEN,
  localparam int unsigned IW      = $clog2(ROB_SIZE),
  localparam int unsigned TW      = IW + 1
) (
  input  logic            clock,
  input  logic            reset,
  // allocation
  input  logic            alloc_valid,
  output logic            alloc_ready,
  input  logic [4:0]      alloc_rd,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic [31:0]     alloc_inst,
  output logic [TW-1:0]   alloc_dest,
  // operand lookup
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [TW-1:0]   qj,
  output logic [TW-1:0]   qk,
  output logic [XLEN-1:0] vj,
  output logic [XLEN-1:0] vk,
  output logic            vj_fwd,
  output logic            vk_fwd,
  // writeback
  input  logic            wb_valid,
  input  logic [TW-1:0]   wb_dest,
  input  logic [XLEN-1:0] wb_result,
  input  logic [XLEN-1:0] wb_npc,
  input  logic            wb_pc_change,
  input  logic            wb_ebreak,
  // commit
  output logic            cmt_valid,
  output logic [4:0]      cmt_rd,
  output logic [XLEN-1:0] cmt_data,
  output logic [XLEN-1:0] cmt_pc,
  output logic [XLEN-1:0] cmt_npc,
  output logic [31:0]     cmt_inst,
  output logic            cmt_ebreak,
  output logic            flush
);

  localparam int unsigned CW = IW + 1;

  // entry storage
  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_done;
  logic [ROB_SIZE-1:0] r_pc_change;
  logic [ROB_SIZE-1:0] r_ebreak;
  logic [4:0]          r_rd     [ROB_SIZE];
  logic [XLEN-1:0]     r_pc     [ROB_SIZE];
  logic [31:0]         r_inst   [ROB_SIZE];
  logic [XLEN-1:0]     r_result [ROB_SIZE];
  logic [XLEN-1:0]     r_npc    [ROB_SIZE];

  // rename map: architectural register -> youngest in-flight producer tag
  logic [TW-1:0]       r_map [32];

  logic [IW-1:0]       r_head;
  logic [IW-1:0]       r_tail;
  logic [CW-1:0]       r_count;

  logic                r_cmt_valid;
  logic [4:0]          r_cmt_rd;
  logic [XLEN-1:0]     r_cmt_data;
  logic [XLEN-1:0]     r_cmt_pc;
  logic [XLEN-1:0]     r_cmt_npc;
  logic [31:0]         r_cmt_inst;
  logic                r_cmt_ebreak;
  logic                r_flush;

  logic                w_alloc;
  logic                w_wb;
  logic [IW-1:0]       w_wb_idx;
  logic                w_retire;
  logic                w_flush;
  logic [TW-1:0]       w_ret_tag;
  logic [4:0]          w_ret_rd;

  assign alloc_ready = (r_count < CW'(ROB_SIZE));
  assign alloc_dest  = {1'b0, r_tail} + TW'(1);
  assign w_alloc     = alloc_valid && alloc_ready;

  // Out-of-range tags are ignored just like tag 0.
  assign w_wb_idx = IW'(wb_dest - TW'(1));
  assign w_wb     = wb_valid && (wb_dest != '0) && (wb_dest <= TW'(ROB_SIZE)) &&
                    r_busy[w_wb_idx];

  // Retire decision uses pre-edge done, so a result retires one edge after its writeback.
  assign w_retire  = r_busy[r_head] && r_done[r_head];
  assign w_flush   = w_retire && r_pc_change[r_head];
  assign w_ret_tag = {1'b0, r_head} + TW'(1);
  assign w_ret_rd  = r_rd[r_head];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy       <= '0;
      r_done       <= '0;
      r_pc_change  <= '0;
      r_ebreak     <= '0;
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        r_rd[i]     <= '0;
        r_pc[i]     <= '0;
        r_inst[i]   <= '0;
        r_result[i] <= '0;
        r_npc[i]    <= '0;
      end
      for (int i = 0; i < 32; i++) r_map[i] <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_cmt_valid  <= 1'b0;
      r_cmt_rd     <= '0;
      r_cmt_data   <= '0;
      r_cmt_pc     <= '0;
      r_cmt_npc    <= '0;
      r_cmt_inst   <= '0;
      r_cmt_ebreak <= 1'b0;
      r_flush      <= 1'b0;
    end else begin
      r_cmt_valid  <= w_retire;
      r_cmt_ebreak <= w_retire && r_ebreak[r_head];
      r_flush      <= w_flush;
      if (w_retire) begin
        r_cmt_rd   <= w_ret_rd;
        r_cmt_data <= r_result[r_head];
        r_cmt_pc   <= r_pc[r_head];
        r_cmt_npc  <= r_npc[r_head];
        r_cmt_inst <= r_inst[r_head];
      end

      if (w_wb) begin
        r_done[w_wb_idx]      <= 1'b1;
        r_result[w_wb_idx]    <= wb_result;
        r_npc[w_wb_idx]       <= wb_npc;
        r_pc_change[w_wb_idx] <= wb_pc_change;
        r_ebreak[w_wb_idx]    <= wb_ebreak;
      end

      if (w_retire) begin
        r_busy[r_head] <= 1'b0;
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + IW'(1);
        if (r_map[w_ret_rd] == w_ret_tag) r_map[w_ret_rd] <= '0;
      end

      // Placed after the retire clear so a same-cycle allocation to that rd wins.
      if (w_alloc) begin
        r_busy[r_tail]      <= 1'b1;
        r_done[r_tail]      <= 1'b0;
        r_pc_change[r_tail] <= 1'b0;
        r_ebreak[r_tail]    <= 1'b0;
        r_rd[r_tail]        <= alloc_rd;
        r_pc[r_tail]        <= alloc_pc;
        r_inst[r_tail]      <= alloc_inst;
        r_tail              <= r_tail + IW'(1);
        if (alloc_rd != 5'd0) r_map[alloc_rd] <= alloc_dest;
      end

      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Redirect squashes everything, including an allocation on this same edge.
      if (w_flush) begin
        r_busy  <= '0;
        r_done  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        for (int i = 0; i < 32; i++) r_map[i] <= '0;
      end
    end
  end

  assign cmt_valid  = r_cmt_valid;
  assign cmt_rd     = r_cmt_rd;
  assign cmt_data   = r_cmt_data;
  assign cmt_pc     = r_cmt_pc;
  assign cmt_npc    = r_cmt_npc;
  assign cmt_inst   = r_cmt_inst;
  assign cmt_ebreak = r_cmt_ebreak;
  assign flush      = r_flush;

  // Operand lookup; a writeback in the current cycle is deliberately not bypassed.
  logic [TW-1:0] w_map_j;
  logic [TW-1:0] w_map_k;
  logic [IW-1:0] w_j_idx;
  logic [IW-1:0] w_k_idx;

  always_comb begin
    w_map_j = (rs1 == 5'd0) ? '0 : r_map[rs1];
    w_map_k = (rs2 == 5'd0) ? '0 : r_map[rs2];
    w_j_idx = IW'(w_map_j - TW'(1));
    w_k_idx = IW'(w_map_k - TW'(1));
    qj      = '0;
    vj      = '0;
    vj_fwd  = 1'b0;
    qk      = '0;
    vk      = '0;
    vk_fwd  = 1'b0;
    if (w_map_j != '0) begin
      if (r_done[w_j_idx]) begin
        vj_fwd = 1'b1;
        vj     = r_result[w_j_idx];
      end else begin
        qj = w_map_j;
      end
    end
    if (w_map_k != '0) begin
      if (r_done[w_k_idx]) begin
        vk_fwd = 1'b1;
        vk     = r_result[w_k_idx];
      end else begin
        qk = w_map_k;
      end
    end
  end

endmodule
